// File: rtl/axis_frame_mon_pkg.sv
// Shared types and helpers for the AXI4-Stream frame monitor.
// Optional checksum output is enabled with AXIS_FRAME_MON_CHECKSUM_EN.
package axis_frame_mon_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int unsigned ERR_SOF       = 0;
    localparam int unsigned ERR_EOL_EARLY = 1;
    localparam int unsigned ERR_EOL_LATE  = 2;
    localparam int unsigned ERR_DROP      = 3;
    localparam int unsigned ERR_W         = 4;

    // Adds a small increment to a w-bit counter, clamping at 2^w-1.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [2:0]  inc,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {30'd0, inc};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/axis_frame_mon_pos.sv
// Column/row tracker: latches geometry on SOF, advances on accepted beats,
// and produces line-end, frame-end and early/late end-of-line strobes.
module axis_frame_mon_pos
    import axis_frame_mon_pkg::*;
#(
    parameter int unsigned C_IMG_WW = 12,
    parameter int unsigned C_IMG_HW = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adv,
    input  logic                sof,
    input  logic                last,
    input  logic [C_IMG_WW-1:0] width,
    input  logic [C_IMG_HW-1:0] height,
    output logic [C_IMG_WW-1:0] col,
    output logic [C_IMG_HW-1:0] row,
    output logic                line_end,
    output logic                frame_end,
    output logic                eol_early,
    output logic                eol_late
);

    logic [C_IMG_WW-1:0] col_q, col_d, width_q, width_d, width_eff;
    logic [C_IMG_HW-1:0] row_q, row_d, height_q, height_d, height_eff;
    logic                late_q, late_d, late_eff;
    logic [C_IMG_WW:0]   col_inc;

    always_comb begin
        // An SOF beat is pixel 0 of a fresh frame regardless of prior position.
        width_eff  = sof ? width  : width_q;
        height_eff = sof ? height : height_q;
        col        = sof ? '0 : col_q;
        row        = sof ? '0 : row_q;
        late_eff   = sof ? 1'b0 : late_q;
        col_inc    = {1'b0, col} + {{C_IMG_WW{1'b0}}, 1'b1};

        line_end  = adv & last;
        frame_end = line_end & (height_eff != '0) & (row == height_eff - C_IMG_HW'(1));
        eol_early = line_end & ((width_eff == '0) | (col_inc < {1'b0, width_eff}));
        eol_late  = adv & ~last & ~late_eff & (col == width_eff - C_IMG_WW'(1));

        width_d  = width_q;
        height_d = height_q;
        col_d    = col_q;
        row_d    = row_q;
        late_d   = late_q;
        if (adv) begin
            width_d  = width_eff;
            height_d = height_eff;
            if (last) begin
                col_d  = '0;
                row_d  = frame_end ? '0 : ((&row) ? row : row + C_IMG_HW'(1));
                late_d = 1'b0;
            end else begin
                col_d  = (&col) ? col : col_inc[C_IMG_WW-1:0];
                row_d  = row;
                late_d = late_eff | eol_late;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            late_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            late_q   <= late_d;
        end
    end

endmodule

// File: rtl/axis_frame_mon.sv
// AXI4-Stream video frame monitor: framing checks, per-frame status, counters.
// Define AXIS_FRAME_MON_CHECKSUM_EN to add the 32-bit frame_sum output.
module axis_frame_mon
    import axis_frame_mon_pkg::*;
#(
    parameter int unsigned C_PIXEL_WIDTH = 8,
    parameter int unsigned C_IMG_WW      = 12,
    parameter int unsigned C_IMG_HW      = 12,
    parameter int unsigned C_CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [C_IMG_WW-1:0]      width,
    input  logic [C_IMG_HW-1:0]      height,
    input  logic                     ready_en,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     frame_done,
    output logic                     frame_ok,
    output logic [ERR_W-1:0]         err_flags,
    output logic [C_IMG_WW-1:0]      meas_w,
    output logic [C_IMG_HW-1:0]      meas_h,
    output logic [C_CNT_W-1:0]       err_cnt,
    output logic [C_CNT_W-1:0]       frame_cnt
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
    ,
    output logic [31:0]              frame_sum
`endif
);

    state_t              state_q, state_d;
    logic [ERR_W-1:0]    flags_q, flags_d, err_flags_q, err_flags_d, beat_flags;
    logic                frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
    logic [C_IMG_WW-1:0] meas_w_q, meas_w_d, col;
    logic [C_IMG_HW-1:0] meas_h_q, meas_h_d, row;
    logic [C_CNT_W-1:0]  err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d;
    logic                accept, active, sof, adv, drop, sof_close, end_close;
    logic                line_end, frame_end, eol_early, eol_late;
    logic [2:0]          n_evt;

    assign s_axis_tready = ready_en & ~reset;

    axis_frame_mon_pos #(
        .C_IMG_WW (C_IMG_WW),
        .C_IMG_HW (C_IMG_HW)
    ) u_pos (
        .clk       (clk),
        .reset     (reset),
        .adv       (adv),
        .sof       (sof),
        .last      (s_axis_tlast),
        .width     (width),
        .height    (height),
        .col       (col),
        .row       (row),
        .line_end  (line_end),
        .frame_end (frame_end),
        .eol_early (eol_early),
        .eol_late  (eol_late)
    );

    always_comb begin
        accept    = s_axis_tvalid & s_axis_tready;
        active    = (state_q == ACTIVE);
        sof       = accept & s_axis_tuser;
        adv       = accept & (active | s_axis_tuser);
        drop      = accept & ~active & ~s_axis_tuser;
        sof_close = sof & active;
        // An early-SOF beat that also ends a line belongs to the new frame only.
        end_close = frame_end & ~sof_close;

        beat_flags                = '0;
        beat_flags[ERR_EOL_EARLY] = eol_early;
        beat_flags[ERR_EOL_LATE]  = eol_late;
        n_evt = {2'b0, drop} + {2'b0, sof_close} + {2'b0, eol_early} + {2'b0, eol_late};

        state_d      = state_q;
        flags_d      = flags_q;
        err_flags_d  = err_flags_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        meas_w_d     = line_end ? col + C_IMG_WW'(1) : meas_w_q;
        meas_h_d     = meas_h_q;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = C_CNT_W'(sat_add(32'(err_cnt_q), n_evt, C_CNT_W));

        if (drop)
            flags_d[ERR_DROP] = 1'b1;
        if (sof_close) begin
            frame_done_d         = 1'b1;
            frame_ok_d           = 1'b0;
            err_flags_d          = flags_q;
            err_flags_d[ERR_SOF] = 1'b1;
            frame_cnt_d          = frame_cnt_q + C_CNT_W'(1);
            flags_d              = beat_flags;
        end else if (adv) begin
            flags_d = flags_q | beat_flags;
        end
        if (sof)
            state_d = ACTIVE;
        if (end_close) begin
            frame_done_d = 1'b1;
            frame_ok_d   = (flags_d == '0);
            err_flags_d  = flags_d;
            meas_h_d     = row + C_IMG_HW'(1);
            frame_cnt_d  = frame_cnt_q + C_CNT_W'(1);
            flags_d      = '0;
            state_d      = WAIT_SOF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            flags_q      <= '0;
            err_flags_q  <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            meas_w_q     <= '0;
            meas_h_q     <= '0;
            err_cnt_q    <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            err_flags_q  <= err_flags_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            meas_w_q     <= meas_w_d;
            meas_h_q     <= meas_h_d;
            err_cnt_q    <= err_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_flags  = err_flags_q;
    assign meas_w     = meas_w_q;
    assign meas_h     = meas_h_q;
    assign err_cnt    = err_cnt_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef AXIS_FRAME_MON_CHECKSUM_EN
    logic [31:0] sum_q, sum_d, frame_sum_q, frame_sum_d, pix;

    always_comb begin
        pix         = 32'(s_axis_tdata);
        sum_d       = sum_q;
        frame_sum_d = frame_sum_q;
        if (sof_close)
            frame_sum_d = sum_q;
        if (sof)
            sum_d = pix;
        else if (adv)
            sum_d = sum_q + pix;
        if (end_close) begin
            frame_sum_d = sum_d;
            sum_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            sum_q       <= sum_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    logic unused_tdata;
    always_comb unused_tdata = ^s_axis_tdata;
`endif

endmodule

// File: tb/tb_axis_frame_mon.sv
// Directed self-checking bench for axis_frame_mon (40x20 geometry, throttled).
// Checks frame_sum too when AXIS_FRAME_MON_CHECKSUM_EN is defined.
module tb_axis_frame_mon;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] width = 12'd40;
    logic [11:0] height = 12'd20;
    logic        ready_en = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready, frame_done, frame_ok;
    logic [3:0]  err_flags;
    logic [11:0] meas_w, meas_h;
    logic [15:0] err_cnt, frame_cnt;
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
    logic [31:0] frame_sum;
`endif

    int          errors = 0;
    int          checks = 0;
    int unsigned phase = 0;
    int unsigned dones = 0;
    logic        last_done = 1'b0;

    always #5 clk = ~clk;

    axis_frame_mon #(
        .C_PIXEL_WIDTH (8),
        .C_IMG_WW      (12),
        .C_IMG_HW      (12),
        .C_CNT_W       (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .width         (width),
        .height        (height),
        .ready_en      (ready_en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .err_flags     (err_flags),
        .meas_w        (meas_w),
        .meas_h        (meas_h),
        .err_cnt       (err_cnt),
        .frame_cnt     (frame_cnt)
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
        ,
        .frame_sum     (frame_sum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One beat under a fixed valid-gap / ready throttle pattern; counts done pulses.
    task automatic beat(input logic u, input logic l, input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) begin
            phase++;
            s_axis_tvalid = (phase % 7) != 3;
            ready_en      = (phase % 5) != 4;
            s_axis_tuser  = u;
            s_axis_tlast  = l;
            s_axis_tdata  = d;
            acc = s_axis_tvalid && ready_en;
            @(posedge clk);
            #1;
            if (frame_done === 1'b1)
                dones++;
            last_done = frame_done;
        end
        s_axis_tvalid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout observed=0 expected=1");
        end
    endtask

    task automatic line(input int unsigned start, input int unsigned len,
                        input logic first_user, input logic with_last);
        for (int unsigned i = 0; i < len; i++)
            beat(first_user && i == 0, with_last && i == len - 1, 8'(128 + start + i));
    endtask

    task automatic lines(input int unsigned n, input logic first_user);
        for (int unsigned r = 0; r < n; r++)
            line(0, 40, first_user && r == 0, 1'b1);
    endtask

    task automatic close_chk(input string tag, input int unsigned exp_dones,
                             input logic exp_ok, input logic [3:0] exp_fl,
                             input int unsigned exp_w, input int unsigned exp_h,
                             input int unsigned exp_ec, input int unsigned exp_fc);
        chk({tag, ".done_on_last"}, 32'(last_done), 32'd1);
        chk({tag, ".dones"},        dones,          exp_dones);
        chk({tag, ".ok"},           32'(frame_ok),  32'(exp_ok));
        chk({tag, ".flags"},        32'(err_flags), 32'(exp_fl));
        chk({tag, ".meas_w"},       32'(meas_w),    exp_w);
        chk({tag, ".meas_h"},       32'(meas_h),    exp_h);
        chk({tag, ".err_cnt"},      32'(err_cnt),   exp_ec);
        chk({tag, ".frame_cnt"},    32'(frame_cnt), exp_fc);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".done"},      32'(frame_done), 32'd0);
        chk({tag, ".ok"},        32'(frame_ok),   32'd0);
        chk({tag, ".flags"},     32'(err_flags),  32'd0);
        chk({tag, ".meas_w"},    32'(meas_w),     32'd0);
        chk({tag, ".meas_h"},    32'(meas_h),     32'd0);
        chk({tag, ".err_cnt"},   32'(err_cnt),    32'd0);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: tready held low, all status zero afterwards.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.tready", 32'(s_axis_tready), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst.tready_rel", 32'(s_axis_tready), 32'd1);
        ready_en = 1'b0;
        #1;
        chk("tready_follows_en", 32'(s_axis_tready), 32'd0);
        zero_chk("rst");

        // Five beats without SOF are dropped; first frame carries flag [3].
        for (int i = 0; i < 5; i++)
            beat(1'b0, 1'b0, 8'hFF);
        chk("drop.err_cnt", 32'(err_cnt), 32'd5);
        chk("drop.no_done", dones, 32'd0);
        lines(20, 1'b1);
        close_chk("dropfrm", 1, 1'b0, 4'b1000, 40, 20, 5, 1);
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
        chk("dropfrm.sum", frame_sum, 32'd118000);
`endif

        // Clean 40x20 frame.
        lines(20, 1'b1);
        close_chk("good", 2, 1'b1, 4'b0000, 40, 20, 5, 2);
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
        chk("good.sum", frame_sum, 32'd118000);
`endif

        // Row 3 ends after 37 pixels.
        lines(3, 1'b1);
        line(0, 37, 1'b0, 1'b1);
        lines(16, 1'b0);
        close_chk("early_eol", 3, 1'b0, 4'b0010, 40, 20, 6, 3);

        // Row 5 runs to 41 pixels before tlast.
        lines(5, 1'b1);
        line(0, 41, 1'b0, 1'b1);
        lines(14, 1'b0);
        close_chk("late_eol", 4, 1'b0, 4'b0100, 40, 20, 7, 4);

        // SOF at row 10, col 0 closes immediately; new frame then completes.
        lines(10, 1'b1);
        chk("esof.no_done_yet", dones, 32'd4);
        beat(1'b1, 1'b0, 8'd128);
        close_chk("esof", 5, 1'b0, 4'b0001, 40, 20, 8, 5);
        line(1, 39, 1'b0, 1'b1);
        lines(19, 1'b0);
        close_chk("esof_next", 6, 1'b1, 4'b0000, 40, 20, 8, 6);
`ifdef AXIS_FRAME_MON_CHECKSUM_EN
        chk("esof_next.sum", frame_sum, 32'd118000);
`endif

        // SOF+tlast mid-frame: close first, then a 1-pixel line of the new frame.
        lines(5, 1'b1);
        beat(1'b1, 1'b1, 8'd128);
        chk("sof_last.done", 32'(last_done), 32'd1);
        chk("sof_last.flags", 32'(err_flags), 32'd1);
        chk("sof_last.err_cnt", 32'(err_cnt), 32'd10);
        chk("sof_last.frame_cnt", 32'(frame_cnt), 32'd7);
        lines(19, 1'b0);
        close_chk("sof_last_next", 8, 1'b0, 4'b0010, 40, 20, 10, 8);

        // width=0: each tlast flags early EOL; frame closes only on next SOF.
        width = 12'd0;
        line(0, 2, 1'b1, 1'b1);
        line(0, 2, 1'b0, 1'b1);
        line(0, 2, 1'b0, 1'b1);
        chk("w0.no_close", dones, 32'd8);
        chk("w0.err_cnt", 32'(err_cnt), 32'd13);
        width = 12'd40;
        beat(1'b1, 1'b0, 8'd128);
        close_chk("w0", 9, 1'b0, 4'b0011, 2, 20, 14, 9);
        line(1, 39, 1'b0, 1'b1);
        lines(19, 1'b0);
        close_chk("w0_next", 10, 1'b1, 4'b0000, 40, 20, 14, 10);

        // Reset mid-frame discards the frame and clears everything.
        lines(3, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (frame_done === 1'b1)
            dones++;
        reset = 1'b0;
        zero_chk("midrst");
        lines(20, 1'b1);
        close_chk("after_rst", 11, 1'b1, 4'b0000, 40, 20, 0, 1);

        // Done must be a single-cycle pulse.
        @(posedge clk);
        #1;
        chk("done_pulse_low", 32'(frame_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
